// File: rtl/fmac_prod_align.sv
// fmac_prod_align: FMAC product/addend alignment stage, 2-cycle valid/ready pipeline
// Inputs: unpacked sign/exp/mant and class flags of a, b, c plus fused-op Cmd_DI.
// Outputs: 48-bit product, signed product exponent, aligned addend window with sticky,
// effective signs, addend-dominance, product-zero and NaN/Inf special result with NV.
// Optional FMAC_PROD_ALIGN_FLUSH_EN adds Flush_SI, which drops both valid bits.
module fmac_prod_align #(
  parameter int C_EXP         = 8,
  parameter int C_MANT        = 23,
  parameter int C_BIAS        = 127,
  parameter int C_EXP_PRENORM = C_EXP + 2,
  parameter int C_ALIGN       = 3 * (C_MANT + 1) + 2
) (
  input  logic                     Clk_CI,
  input  logic                     Rst_RBI,
`ifdef FMAC_PROD_ALIGN_FLUSH_EN
  input  logic                     Flush_SI,
`endif
  input  logic                     Valid_SI,
  output logic                     Ready_SO,
  input  logic [3:0]               Cmd_DI,
  input  logic                     Sign_a_DI,
  input  logic                     Sign_b_DI,
  input  logic                     Sign_c_DI,
  input  logic [C_EXP-1:0]         Exp_a_DI,
  input  logic [C_EXP-1:0]         Exp_b_DI,
  input  logic [C_EXP-1:0]         Exp_c_DI,
  input  logic [C_MANT:0]          Mant_a_DI,
  input  logic [C_MANT:0]          Mant_b_DI,
  input  logic [C_MANT:0]          Mant_c_DI,
  input  logic                     Inf_a_SI,
  input  logic                     Inf_b_SI,
  input  logic                     Inf_c_SI,
  input  logic                     Zero_a_SI,
  input  logic                     Zero_b_SI,
  input  logic                     Zero_c_SI,
  input  logic                     NaN_a_SI,
  input  logic                     NaN_b_SI,
  input  logic                     NaN_c_SI,
  output logic                     Valid_SO,
  input  logic                     Ready_DI,
  output logic [2*C_MANT+1:0]      Mant_prod_DO,
  output logic [C_EXP_PRENORM-1:0] Exp_prod_DO,
  output logic                     Sign_prod_DO,
  output logic [C_ALIGN-1:0]       Mant_c_aligned_DO,
  output logic                     Sticky_c_SO,
  output logic                     Sign_c_DO,
  output logic                     Addend_dom_SO,
  output logic                     Prod_zero_SO,
  output logic                     Special_SO,
  output logic [31:0]              Special_res_DO,
  output logic                     NV_SO
);
  localparam int C_M   = C_MANT + 1;
  localparam int C_PAD = C_ALIGN - C_M;
  localparam int C_SH  = C_EXP_PRENORM + 1;
  localparam logic [31:0] C_QNAN = 32'h7FC00000;
  logic w_flush;
`ifdef FMAC_PROD_ALIGN_FLUSH_EN
  assign w_flush = Flush_SI;
`else
  assign w_flush = 1'b0;
`endif
  logic r_rst_done, r_s1_valid, r_s2_valid;
  logic w_s2_ready, w_in_xfer, w_s1_xfer;
  assign w_s2_ready = ~r_s2_valid | Ready_DI;
  assign Ready_SO   = r_rst_done & ~w_flush & (~r_s1_valid | w_s2_ready);
  assign w_in_xfer  = Valid_SI & Ready_SO;
  assign w_s1_xfer  = r_s1_valid & w_s2_ready & ~w_flush;
  assign Valid_SO   = r_s2_valid;
  // Commands outside 8..B decode as FMADD (no negation).
  logic w_cmd_ok, w_neg_p, w_neg_c, w_sp, w_sc;
  assign w_cmd_ok = Cmd_DI[3:2] == 2'b10;
  assign w_neg_p  = w_cmd_ok & Cmd_DI[1];
  assign w_neg_c  = w_cmd_ok & (Cmd_DI[1] ^ Cmd_DI[0]);
  assign w_sp     = Sign_a_DI ^ Sign_b_DI ^ w_neg_p;
  assign w_sc     = Sign_c_DI ^ w_neg_c;
  logic [C_EXP_PRENORM-1:0] w_exp_prod;
  logic [C_SH-1:0]          w_shift;
  assign w_exp_prod = C_EXP_PRENORM'(Exp_a_DI) + C_EXP_PRENORM'(Exp_b_DI) - C_EXP_PRENORM'(C_BIAS);
  // Offset places the addend MSB at the product's bit 46 when exponents match.
  assign w_shift    = {w_exp_prod[C_EXP_PRENORM-1], w_exp_prod} - C_SH'(Exp_c_DI) + C_SH'(C_MANT + 4);
  logic w_any_nan, w_snan, w_inv_mul, w_pinf, w_inf_sub, w_special, w_nv;
  logic [31:0] w_res;
  assign w_any_nan = NaN_a_SI | NaN_b_SI | NaN_c_SI;
  assign w_snan    = (NaN_a_SI & ~Mant_a_DI[C_MANT-1]) | (NaN_b_SI & ~Mant_b_DI[C_MANT-1]) |
                     (NaN_c_SI & ~Mant_c_DI[C_MANT-1]);
  assign w_inv_mul = (Inf_a_SI & Zero_b_SI) | (Zero_a_SI & Inf_b_SI);
  assign w_pinf    = Inf_a_SI | Inf_b_SI;
  assign w_inf_sub = w_pinf & Inf_c_SI & (w_sp ^ w_sc);
  assign w_special = w_any_nan | w_pinf | Inf_c_SI;
  assign w_nv      = w_any_nan ? w_snan : (w_inv_mul | w_inf_sub);
  assign w_res     = (w_any_nan | w_inv_mul | w_inf_sub) ? C_QNAN :
                     w_pinf   ? {w_sp, 8'hFF, 23'h0} :
                     Inf_c_SI ? {w_sc, 8'hFF, 23'h0} : 32'h0;
  logic                     r1_sign_prod, r1_sign_c, r1_zero_c, r1_prod_zero, r1_special, r1_nv;
  logic [C_EXP_PRENORM-1:0] r1_exp_prod;
  logic [C_SH-1:0]          r1_shift;
  logic [C_MANT:0]          r1_mant_a, r1_mant_b, r1_mant_c;
  logic [31:0]              r1_res;
  logic [C_ALIGN-1:0]       w_win, w_aligned;
  logic [2*C_ALIGN-1:0]     w_wide;
  logic                     w_le0, w_ge, w_sticky;
  // The lower half of the double-width shift holds exactly the bits pushed out.
  assign w_win     = {r1_mant_c, {C_PAD{1'b0}}};
  assign w_wide    = {w_win, {C_ALIGN{1'b0}}} >> r1_shift;
  assign w_le0     = r1_shift[C_SH-1] | ~|r1_shift;
  assign w_ge      = ~r1_shift[C_SH-1] & (r1_shift >= C_SH'(C_ALIGN));
  assign w_aligned = r1_zero_c ? '0 : w_le0 ? w_win : w_ge ? '0 : w_wide[2*C_ALIGN-1:C_ALIGN];
  assign w_sticky  = r1_zero_c ? 1'b0 : w_le0 ? 1'b0 : w_ge ? |r1_mant_c : |w_wide[C_ALIGN-1:0];
  always_ff @(posedge Clk_CI or negedge Rst_RBI)
    if (!Rst_RBI) begin
      r_rst_done <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      r_s1_valid <= ~w_flush & (w_in_xfer | (r_s1_valid & ~w_s2_ready));
      r_s2_valid <= ~w_flush & (w_s1_xfer | (r_s2_valid & ~Ready_DI));
    end
  always_ff @(posedge Clk_CI or negedge Rst_RBI)
    if (!Rst_RBI) begin
      r1_sign_prod <= 1'b0;
      r1_sign_c    <= 1'b0;
      r1_exp_prod  <= '0;
      r1_shift     <= '0;
      r1_mant_a    <= '0;
      r1_mant_b    <= '0;
      r1_mant_c    <= '0;
      r1_zero_c    <= 1'b0;
      r1_prod_zero <= 1'b0;
      r1_special   <= 1'b0;
      r1_res       <= '0;
      r1_nv        <= 1'b0;
    end else if (w_in_xfer) begin
      r1_sign_prod <= w_sp;
      r1_sign_c    <= w_sc;
      r1_exp_prod  <= w_exp_prod;
      r1_shift     <= w_shift;
      r1_mant_a    <= Mant_a_DI;
      r1_mant_b    <= Mant_b_DI;
      r1_mant_c    <= Mant_c_DI;
      r1_zero_c    <= Zero_c_SI;
      r1_prod_zero <= Zero_a_SI | Zero_b_SI;
      r1_special   <= w_special;
      r1_res       <= w_res;
      r1_nv        <= w_nv;
    end
  always_ff @(posedge Clk_CI or negedge Rst_RBI)
    if (!Rst_RBI) begin
      Mant_prod_DO      <= '0;
      Exp_prod_DO       <= '0;
      Sign_prod_DO      <= 1'b0;
      Mant_c_aligned_DO <= '0;
      Sticky_c_SO       <= 1'b0;
      Sign_c_DO         <= 1'b0;
      Addend_dom_SO     <= 1'b0;
      Prod_zero_SO      <= 1'b0;
      Special_SO        <= 1'b0;
      Special_res_DO    <= '0;
      NV_SO             <= 1'b0;
    end else if (w_s1_xfer) begin
      Mant_prod_DO      <= r1_mant_a * r1_mant_b;
      Exp_prod_DO       <= r1_exp_prod;
      Sign_prod_DO      <= r1_sign_prod;
      Mant_c_aligned_DO <= w_aligned;
      Sticky_c_SO       <= w_sticky;
      Sign_c_DO         <= r1_sign_c;
      Addend_dom_SO     <= r1_shift[C_SH-1];
      Prod_zero_SO      <= r1_prod_zero;
      Special_SO        <= r1_special;
      Special_res_DO    <= r1_res;
      NV_SO             <= r1_nv;
    end
endmodule

// File: tb/tb_fmac_prod_align.sv
// tb_fmac_prod_align: randomized + directed check of fmac_prod_align against a behavioural model
module tb_fmac_prod_align;
  typedef struct packed {
    logic [3:0] cmd;
    logic sa, sb, sc;
    logic [7:0] ea, eb, ec;
    logic [23:0] ma, mb, mc;
    logic ia, ib, ic, za, zb, zc, na, nb, nc;
  } op_t;
  typedef struct packed {
    logic [47:0] mp;
    logic [9:0] ep;
    logic sp;
    logic [73:0] al;
    logic st, sc, dom, pz, spc;
    logic [31:0] res;
    logic nv;
  } exp_t;
  logic Clk_CI = 1'b0, Rst_RBI, Valid_SI, Ready_SO, Ready_DI, Valid_SO;
  op_t cur;
  logic [47:0] Mant_prod_DO;
  logic [9:0] Exp_prod_DO;
  logic [73:0] Mant_c_aligned_DO;
  logic [31:0] Special_res_DO;
  logic Sign_prod_DO, Sticky_c_SO, Sign_c_DO, Addend_dom_SO, Prod_zero_SO, Special_SO, NV_SO;
  int n_vec = 0, n_err = 0;
  exp_t q[$];
  always #5 Clk_CI = ~Clk_CI;
  fmac_prod_align dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI), .Valid_SI(Valid_SI), .Ready_SO(Ready_SO), .Cmd_DI(cur.cmd),
    .Sign_a_DI(cur.sa), .Sign_b_DI(cur.sb), .Sign_c_DI(cur.sc),
    .Exp_a_DI(cur.ea), .Exp_b_DI(cur.eb), .Exp_c_DI(cur.ec),
    .Mant_a_DI(cur.ma), .Mant_b_DI(cur.mb), .Mant_c_DI(cur.mc),
    .Inf_a_SI(cur.ia), .Inf_b_SI(cur.ib), .Inf_c_SI(cur.ic),
    .Zero_a_SI(cur.za), .Zero_b_SI(cur.zb), .Zero_c_SI(cur.zc),
    .NaN_a_SI(cur.na), .NaN_b_SI(cur.nb), .NaN_c_SI(cur.nc),
    .Valid_SO(Valid_SO), .Ready_DI(Ready_DI), .Mant_prod_DO(Mant_prod_DO), .Exp_prod_DO(Exp_prod_DO),
    .Sign_prod_DO(Sign_prod_DO), .Mant_c_aligned_DO(Mant_c_aligned_DO), .Sticky_c_SO(Sticky_c_SO),
    .Sign_c_DO(Sign_c_DO), .Addend_dom_SO(Addend_dom_SO), .Prod_zero_SO(Prod_zero_SO),
    .Special_SO(Special_SO), .Special_res_DO(Special_res_DO), .NV_SO(NV_SO)
  );
  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask
  function automatic exp_t pack_dut();
    return '{Mant_prod_DO, Exp_prod_DO, Sign_prod_DO, Mant_c_aligned_DO, Sticky_c_SO, Sign_c_DO,
             Addend_dom_SO, Prod_zero_SO, Special_SO, Special_res_DO, NV_SO};
  endfunction
  function automatic exp_t model(input op_t o);
    exp_t e;
    int ep, sh;
    logic [3:0] cmd;
    logic [73:0] w;
    bit neg_p, neg_c;
    e = '0;
    cmd = (o.cmd >= 4'h8 && o.cmd <= 4'hB) ? o.cmd : 4'h8;
    neg_p = (cmd == 4'hA) || (cmd == 4'hB);
    neg_c = (cmd == 4'h9) || (cmd == 4'hA);
    e.sp = o.sa ^ o.sb ^ neg_p;
    e.sc = o.sc ^ neg_c;
    ep = int'(o.ea) + int'(o.eb) - 127;
    e.ep = 10'(ep);
    sh = ep - int'(o.ec) + 27;
    e.mp = 48'(o.ma) * 48'(o.mb);
    w = {o.mc, 50'b0};
    e.dom = sh < 0;
    if (!o.zc) begin
      if (sh <= 0) e.al = w;
      else for (int i = 0; i < 74; i++) begin
        if (i + sh < 74) e.al[i] = w[i+sh];
        if (i < sh) e.st = e.st | w[i];
      end
    end
    e.pz = o.za | o.zb;
    if (o.na || o.nb || o.nc) begin
      e.spc = 1; e.res = 32'h7FC00000;
      e.nv = (o.na && !o.ma[22]) || (o.nb && !o.mb[22]) || (o.nc && !o.mc[22]);
    end else if ((o.ia && o.zb) || (o.za && o.ib)) begin
      e.spc = 1; e.nv = 1; e.res = 32'h7FC00000;
    end else if ((o.ia || o.ib) && o.ic && e.sp != e.sc) begin
      e.spc = 1; e.nv = 1; e.res = 32'h7FC00000;
    end else if (o.ia || o.ib) begin
      e.spc = 1; e.res = {e.sp, 8'hFF, 23'h0};
    end else if (o.ic) begin
      e.spc = 1; e.res = {e.sc, 8'hFF, 23'h0};
    end
    return e;
  endfunction
  function automatic op_t mk(input logic [3:0] cmd, input logic [7:0] ea, input logic [23:0] ma,
                             input logic [7:0] eb, input logic [23:0] mb, input logic [7:0] ec,
                             input logic [23:0] mc);
    op_t o;
    o = '0;
    o.cmd = cmd; o.ea = ea; o.ma = ma; o.eb = eb; o.mb = mb; o.ec = ec; o.mc = mc;
    return o;
  endfunction
  function automatic void rnd_class(output logic i, output logic z, output logic n);
    int r;
    r = $urandom_range(0, 19);
    i = r == 0; z = r == 1; n = r == 2;
  endfunction
  function automatic op_t rnd();
    op_t o;
    int ep, ec;
    o.cmd = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(8 + $urandom_range(0, 3));
    o.sa = 1'($urandom); o.sb = 1'($urandom); o.sc = 1'($urandom);
    o.ea = 8'($urandom_range(0, 7) == 0 ? $urandom_range(1, 20) : $urandom_range(1, 254));
    o.eb = 8'($urandom_range(1, 254));
    ep = int'(o.ea) + int'(o.eb) - 127;
    ec = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 254)) : ep + 27 - (int'($urandom_range(0, 100)) - 13);
    o.ec = 8'(ec < 1 ? 1 : ec > 254 ? 254 : ec);
    o.ma = {1'b1, 23'($urandom)}; o.mb = {1'b1, 23'($urandom)};
    o.mc = ($urandom_range(0, 7) == 0) ? 24'($urandom_range(1, 255)) : {1'b1, 23'($urandom)};
    rnd_class(o.ia, o.za, o.na);
    rnd_class(o.ib, o.zb, o.nb);
    rnd_class(o.ic, o.zc, o.nc);
    return o;
  endfunction
  logic have_prev = 0;
  logic [191:0] prev;
  always @(negedge Clk_CI) begin
    if (!Rst_RBI) begin
      q.delete();
      have_prev = 0;
    end else begin
      if (have_prev) chk("stall_hold", {Valid_SO, pack_dut()}, prev);
      have_prev = Valid_SO & ~Ready_DI;
      prev = {Valid_SO, pack_dut()};
      if (Valid_SO && Ready_DI) begin
        if (q.size() == 0) chk("unexpected_out", Valid_SO, 0);
        else chk("result", pack_dut(), q.pop_front());
      end
      if (Valid_SI && Ready_SO) q.push_back(model(cur));
    end
  end
  task automatic send(input op_t o);
    int n;
    bit ok;
    n = 0;
    cur = o; Valid_SI = 1;
    do begin
      @(negedge Clk_CI) ok = Ready_SO;
      @(posedge Clk_CI) #2;
      n++;
    end while (!ok && n < 20);
    Valid_SI = 0;
    chk("send_accept", ok, 1);
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge Clk_CI);
      lat++;
    end while (!(Valid_SO && Ready_DI) && lat < 20);
    chk("out_valid", Valid_SO, 1);
  endtask
  task automatic drain();
    int n;
    n = 0;
    Valid_SI = 0; Ready_DI = 1;
    while (q.size() != 0 && n < 30) begin
      @(negedge Clk_CI);
      n++;
    end
    @(posedge Clk_CI) #2;
    chk("drain_empty", q.size(), 0);
  endtask
  task automatic stream(input int n_ops);
    int sent, cyc;
    bit x;
    sent = 0; cyc = 0;
    cur = rnd();
    while (sent < n_ops && cyc < 20 * n_ops) begin
      Ready_DI = 1'($urandom_range(0, 3) != 0);
      Valid_SI = 1'($urandom_range(0, 3) != 0);
      @(negedge Clk_CI) x = Valid_SI & Ready_SO;
      @(posedge Clk_CI) #2;
      if (x) begin
        sent++;
        cur = rnd();
      end
      cyc++;
    end
    chk("stream_sent", sent, n_ops);
    drain();
  endtask
  initial begin
    op_t o;
    exp_t e;
    int lat;
    bit x;
    logic [3:0] pat;
    cur = '0; Valid_SI = 0; Ready_DI = 1; Rst_RBI = 0;
    repeat (3) @(posedge Clk_CI);
    @(negedge Clk_CI);
    chk("rst_valid", Valid_SO, 0);
    chk("rst_outputs", pack_dut(), 0);
    @(posedge Clk_CI) #2 Rst_RBI = 1;
    @(posedge Clk_CI);
    @(negedge Clk_CI) chk("ready_after_rst", Ready_SO, 1);
    @(posedge Clk_CI) #2;
    o = mk(4'h8, 8'd127, 24'h800000, 8'd127, 24'h800000, 8'd127, 24'h800000);
    e = model(o);
    chk("model_1p1_prod", e.mp, 48'h4000_0000_0000);
    chk("model_1p1_align", e.al, 74'(1) << 46);
    send(o);
    wait_out(lat);
    chk("lat_1p1", lat, 2);
    chk("prod_1p1", Mant_prod_DO, 48'h4000_0000_0000);
    chk("exp_1p1", Exp_prod_DO, 10'd127);
    chk("align_1p1", Mant_c_aligned_DO, 74'(1) << 46);
    chk("sticky_1p1", Sticky_c_SO, 0);
    chk("special_1p1", Special_SO, 0);
    o = mk(4'h9, 8'd127, 24'h800000, 8'd127, 24'h800000, 8'd1, 24'h000001);
    e = model(o);
    chk("model_denorm_sticky", e.st, 1);
    send(o);
    wait_out(lat);
    chk("align_denorm", Mant_c_aligned_DO, 0);
    chk("sticky_denorm", Sticky_c_SO, 1);
    chk("signc_fmsub", Sign_c_DO, 1);
    o = mk(4'h8, 8'd255, 24'h800000, 8'd1, 24'h0, 8'd127, 24'h800000);
    o.ia = 1; o.zb = 1;
    send(o);
    wait_out(lat);
    chk("infzero_special", Special_SO, 1);
    chk("infzero_nv", NV_SO, 1);
    chk("infzero_res", Special_res_DO, 32'h7FC00000);
    o = mk(4'h8, 8'd127, 24'h800000, 8'd127, 24'h800000, 8'd255, 24'hA00000);
    o.nc = 1;
    send(o);
    wait_out(lat);
    chk("snan_nv", NV_SO, 1);
    chk("snan_res", Special_res_DO, 32'h7FC00000);
    o = mk(4'h9, 8'd255, 24'h800000, 8'd127, 24'h800000, 8'd255, 24'h800000);
    o.ia = 1; o.ic = 1;
    send(o);
    wait_out(lat);
    chk("infsub_nv", NV_SO, 1);
    chk("infsub_res", Special_res_DO, 32'h7FC00000);
    o.cmd = 4'h8;
    send(o);
    wait_out(lat);
    chk("infadd_nv", NV_SO, 0);
    chk("infadd_res", Special_res_DO, 32'h7F800000);
    @(posedge Clk_CI) #2;
    Ready_DI = 0; cur = rnd(); Valid_SI = 1;
    @(posedge Clk_CI) #2 cur = rnd();
    @(posedge Clk_CI) #2 cur = rnd();
    @(negedge Clk_CI);
    chk("ready_full_stall", Ready_SO, 0);
    chk("valid_full_stall", Valid_SO, 1);
    pat = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      Ready_DI = pat[3-k];
      @(negedge Clk_CI) x = Valid_SI & Ready_SO;
      @(posedge Clk_CI) #2;
      if (x) cur = rnd();
    end
    drain();
    stream(300);
    Ready_DI = 0; cur = rnd(); Valid_SI = 1;
    @(posedge Clk_CI) #2 cur = rnd();
    @(posedge Clk_CI) #2 Valid_SI = 0;
    Rst_RBI = 0;
    #1;
    chk("midrst_valid", Valid_SO, 0);
    chk("midrst_outputs", pack_dut(), 0);
    repeat (2) @(posedge Clk_CI);
    #2 Rst_RBI = 1; Ready_DI = 1;
    @(posedge Clk_CI);
    @(negedge Clk_CI) chk("midrst_ready", Ready_SO, 1);
    repeat (4) @(negedge Clk_CI) chk("midrst_no_valid", Valid_SO, 0);
    @(posedge Clk_CI) #2;
    stream(200);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
